// File: rtl/oc_chk_pkg.sv
// Shared definitions for the ones'-complement checksum checker and its adder:
// FSM state encoding and default geometry.
package oc_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } oc_chk_state_t;

    localparam int OC_WIDTH_DEFAULT     = 4;
    localparam int OC_MAX_WORDS_DEFAULT = 15;

endpackage : oc_chk_pkg

// File: rtl/oc_add.sv
// WIDTH-bit end-around-carry (ones'-complement) adder, purely combinational.
// Shared between the checksum checker and the generator side.
module oc_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    // Folding the carry back in cannot carry out again: the low part is at most 2**WIDTH-2 when it is set.
    assign o_sum = w_raw[WIDTH-1:0] + WIDTH'(w_raw[WIDTH]);

endmodule : oc_add

// File: rtl/oc_checksum_checker.sv
// Receive-side ones'-complement checksum checker: accumulates a framed word stream and
// reports pass when the sum is all-ones. Optional macro OC_CHK_ERR_COUNT_EN adds err_count.
module oc_checksum_checker
    import oc_chk_pkg::*;
#(
    parameter int WIDTH     = OC_WIDTH_DEFAULT,
    parameter int MAX_WORDS = OC_MAX_WORDS_DEFAULT,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             pass,
    output logic             overflow,
    output logic [WIDTH-1:0] sum_out,
`ifdef OC_CHK_ERR_COUNT_EN
    output logic [7:0]       err_count,
`endif
    output logic [CNT_W-1:0] word_count
);

    oc_chk_state_t    r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_pass;
    logic             r_ovf;
    logic [WIDTH-1:0] r_sum;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_hit_max;
    logic             w_end;
    logic             w_ovf_next;
    logic             w_pass_next;

    assign w_ready  = (r_state != S_RESULT);
    assign w_accept = in_valid && w_ready;

    // A new frame starts from +0 rather than from the stale accumulator.
    assign w_add_a = (r_state == S_IDLE) ? '0 : r_acc;

    oc_add #(.WIDTH(WIDTH)) u_oc_add (
        .i_a   (w_add_a),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign w_cnt_next  = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_hit_max   = (w_cnt_next == CNT_W'(MAX_WORDS));
    assign w_end       = in_last || w_hit_max;
    assign w_ovf_next  = !in_last && w_hit_max;
    assign w_pass_next = (w_sum == {WIDTH{1'b1}}) && !w_ovf_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_ovf   <= 1'b0;
            r_sum   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_next;
                        if (r_state == S_IDLE) begin
                            r_pass <= 1'b0;
                            r_ovf  <= 1'b0;
                            r_sum  <= '0;
                        end
                        // Results are registered on the final accept so they appear with done.
                        if (w_end) begin
                            r_state <= S_RESULT;
                            r_done  <= 1'b1;
                            r_sum   <= w_sum;
                            r_pass  <= w_pass_next;
                            r_ovf   <= w_ovf_next;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_RESULT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OC_CHK_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_end && !w_pass_next) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign in_ready   = w_ready;
    assign done       = r_done;
    assign pass       = r_pass;
    assign overflow   = r_ovf;
    assign sum_out    = r_sum;
    assign word_count = r_cnt;

endmodule : oc_checksum_checker

// File: tb/tb_oc_checksum_checker.sv
// Directed bench for oc_checksum_checker (MAX_WORDS=4) with a frame-level reference model
// compared on every cycle, plus literal expectations for the key frames.
module tb_oc_checksum_checker;

    localparam int W    = 4;
    localparam int MAXW = 4;
    localparam int CW   = 4;
    localparam int M    = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          done;
    logic          pass;
    logic          overflow;
    logic [W-1:0]  sum_out;
    logic [CW-1:0] word_count;
`ifdef OC_CHK_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    oc_checksum_checker #(.WIDTH(W), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .done       (done),
        .pass       (pass),
        .overflow   (overflow),
        .sum_out    (sum_out),
`ifdef OC_CHK_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .word_count (word_count)
    );

    logic [W-1:0] add_a = '0;
    logic [W-1:0] add_b = '0;
    logic [W-1:0] add_s;
    oc_add #(.WIDTH(W)) u_add_chk (.i_a(add_a), .i_b(add_b), .o_sum(add_s));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ones'-complement sum of non-negative words equals the plain total mod 2**W-1,
    // except that a nonzero multiple maps to -0 (all ones) and only an empty total is +0.
    function automatic int oc_model(input int total);
        return (total == 0) ? 0 : ((total - 1) % M) + 1;
    endfunction

    bit   m_bubble = 1'b0;
    bit   m_infr   = 1'b0;
    int   m_total  = 0;
    int   m_cnt    = 0;
    bit   m_done   = 1'b0;
    bit   m_pass   = 1'b0;
    bit   m_ovf    = 1'b0;
    int   m_sum    = 0;
    int   m_err    = 0;

    always @(posedge clk) begin : model
        int t;
        int c;
        int s;
        bit ov;
        bit ok;
        if (reset) begin
            m_bubble <= 1'b0; m_infr <= 1'b0; m_total <= 0; m_cnt <= 0;
            m_done <= 1'b0; m_pass <= 1'b0; m_ovf <= 1'b0; m_sum <= 0; m_err <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_bubble) begin
                m_bubble <= 1'b0;
            end else if (in_valid) begin
                t = m_infr ? m_total + int'(in_data) : int'(in_data);
                c = m_infr ? m_cnt + 1 : 1;
                if (!m_infr) begin
                    m_pass <= 1'b0; m_ovf <= 1'b0; m_sum <= 0;
                end
                m_total <= t;
                m_cnt   <= c;
                if (in_last || c == MAXW) begin
                    s  = oc_model(t);
                    ov = !in_last;
                    ok = (s == M) && !ov;
                    m_done <= 1'b1; m_bubble <= 1'b1; m_infr <= 1'b0;
                    m_sum <= s; m_ovf <= ov; m_pass <= ok;
                    if (!ok && m_err < 255) m_err <= m_err + 1;
                end else begin
                    m_infr <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready",   int'(in_ready),   int'(!m_bubble));
            check("cyc_done",       int'(done),       int'(m_done));
            check("cyc_pass",       int'(pass),       int'(m_pass));
            check("cyc_overflow",   int'(overflow),   int'(m_ovf));
            check("cyc_sum_out",    int'(sum_out),    m_sum);
            check("cyc_word_count", int'(word_count), m_cnt);
`ifdef OC_CHK_ERR_COUNT_EN
            check("cyc_err_count",  int'(err_count),  m_err);
`endif
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        logic r;
        int   n;
        bit   fin;
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0; fin = 1'b0;
        while (!fin) begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) fin = 1'b1;
            else begin
                n++;
                if (n > 20) begin
                    check("send_timeout", 0, 1);
                    fin = 1'b1;
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        add_a = 4'hF; add_b = 4'h1; #1;
        check("oc_add_F_1", int'(add_s), 1);
        add_a = 4'h9; add_b = 4'h8; #1;
        check("oc_add_9_8", int'(add_s), 2);
        check("model_16", oc_model(16), 1);
        check("model_0", oc_model(0), 0);

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_word_count", int'(word_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        idle(2);

        // Good frame, then back-to-back frame held through the bubble.
        send(4'h3, 1'b0); send(4'h5, 1'b0); send(4'h7, 1'b1);
        check("a_done", int'(done), 1);
        check("a_sum", int'(sum_out), 15);
        check("a_pass", int'(pass), 1);
        check("a_wc", int'(word_count), 3);
        check("a_ready_bubble", int'(in_ready), 0);
        check("a_model_sum", m_sum, 15);
        send(4'h9, 1'b0); send(4'h8, 1'b0); send(4'hD, 1'b1);
        check("b_sum", int'(sum_out), 15);
        check("b_pass", int'(pass), 1);

        // Corrupted checksum.
        send(4'h3, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b1);
        check("c_sum", int'(sum_out), 14);
        check("c_pass", int'(pass), 0);
        check("c_ovf", int'(overflow), 0);
`ifdef OC_CHK_ERR_COUNT_EN
        check("c_err_count", int'(err_count), 1);
`endif
        idle(1);

        // Overflow: four words with no last end the frame.
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        check("o_done", int'(done), 1);
        check("o_ovf", int'(overflow), 1);
        check("o_pass", int'(pass), 0);
        check("o_sum", int'(sum_out), 10);
        check("o_wc", int'(word_count), 4);
        send(4'h5, 1'b0);
        check("o_new_wc", int'(word_count), 1);
        check("o_new_ovf_clr", int'(overflow), 0);
        send(4'hA, 1'b1);
        check("o2_pass", int'(pass), 1);
        check("o2_wc", int'(word_count), 2);
        idle(1);

        // Reset mid-frame discards the frame.
        send(4'h3, 1'b0); send(4'h5, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("r_wc", int'(word_count), 0);
        check("r_sum", int'(sum_out), 0);
        check("r_pass", int'(pass), 0);
        check("r_done", int'(done), 0);
        idle(3);
        send(4'hF, 1'b1);
        check("r2_pass", int'(pass), 1);
        check("r2_wc", int'(word_count), 1);

        // Random gaps mid-frame.
        for (int i = 0; i < 4; i++) begin
            send(4'h3, 1'b0); idle($urandom_range(0, 3));
            send(4'h5, 1'b0); idle($urandom_range(0, 3));
            send(4'h7, 1'b1);
            check("g_pass", int'(pass), 1);
            check("g_sum", int'(sum_out), 15);
            idle($urandom_range(0, 2));
        end

        // All-zero (+0) fails; single non-all-ones word fails.
        send(4'h0, 1'b0); send(4'h0, 1'b1);
        check("z_pass", int'(pass), 0);
        check("z_sum", int'(sum_out), 0);
        send(4'h7, 1'b1);
        check("s_pass", int'(pass), 0);
        check("s_wc", int'(word_count), 1);
        idle(4);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_oc_checksum_checker

// File: doc/oc_checksum_checker.md
Name: oc_checksum_checker

Overview:
- Receive-side partner to the team's 4-bit end-around-carry (ones'-complement) adder used for checksum generation.
- Accepts a framed stream of WIDTH-bit words, the final word being the transmitted checksum, and accumulates their ones'-complement sum.
- At frame end it reports pass when the sum is all-ones, plus the raw sum for debug.
- Sits between the link/word source and the frame consumer.

Parameters:
- WIDTH, 4, word and accumulator width in bits.
- MAX_WORDS, 15, maximum words per frame including the checksum word; must be at least 1.
- CNT_W, 4, width of word_count; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_data  input  WIDTH  data or checksum word.
- in_last  input  1  marks the final (checksum) word of a frame.
- in_ready  output  1  block can accept a word this cycle.
- done  output  1  one-cycle pulse: frame result valid.
- pass  output  1  frame checksum correct; held until next frame starts.
- overflow  output  1  frame exceeded MAX_WORDS; held until next frame starts.
- sum_out  output  WIDTH  final ones'-complement sum; held until next frame starts.
- word_count  output  CNT_W  words accepted in current/last frame.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset values:
  - state=IDLE, acc=0, word_count=0.
  - done=0, pass=0, overflow=0, sum_out=0.
  - in_ready=1 from the first cycle after reset.
- Accept rule: a word is accepted on a rising edge where in_valid && in_ready. in_data and in_last are ignored otherwise.
- Ones'-complement add, acc' = oc(acc, in_data):
  - s = acc + in_data, computed at WIDTH+1 bits.
  - acc' = s[WIDTH-1:0] + s[WIDTH], truncated to WIDTH bits.
  - The second add never carries out.
- States:
  - IDLE: in_ready=1. On accept: acc <= oc(0, in_data), word_count <= 1, clear pass/overflow/sum_out. Then go to RESULT if in_last, otherwise ACCUM.
  - ACCUM: in_ready=1. On accept: acc <= oc(acc, in_data), word_count++. Go to RESULT if in_last or word_count+1 == MAX_WORDS; otherwise stay in ACCUM.
  - RESULT (one cycle): in_ready=0, done=1, sum_out=acc, pass=(acc == all-ones) && !overflow. Then go to IDLE.
- Overflow: the word accepted when word_count reaches MAX_WORDS with in_last=0 ends the frame.
  - overflow=1, pass=0.
  - Subsequent words start a new frame; no resynchronisation to in_last.
- Latency: done is asserted exactly one cycle after the final word is accepted.
- Back-to-back frames lose exactly one cycle (the RESULT bubble).
- all-zero sum (+0) is a fail; only all-ones (-0) passes.
- Single-word frame (in_last on the first word): valid; pass iff the word is all-ones.
- in_valid gaps mid-frame: state and acc hold; no timeout.
- Reset mid-frame: the frame is discarded, all outputs return to reset values, and no done is emitted.
- A word presented during RESULT is not accepted; the source must hold it.

Optional Feature:
- Macro: OC_CHK_ERR_COUNT_EN.
- When defined:
  - Adds output err_count[7:0].
  - It increments (saturating at 255) on every done with pass=0.
  - It clears only on reset.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package oc_chk_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_ACCUM=2'd1, S_RESULT=2'd2.
  - default WIDTH and MAX_WORDS constants.
- One combinational sub-module, oc_add (WIDTH-parameterised end-around-carry adder).
  - The checker instantiates it once, on the accumulator path.
  - It is reusable by the future generator side.

Test Plan:
- Good frame, no wrap: 0x3, 0x5, 0x7(last) -> done one cycle after the last accept, sum_out=0xF, pass=1, word_count=3.
- End-around carry: 0x9, 0x8 (0x11 -> 0x2), 0xD(last) -> sum_out=0xF, pass=1. Also check oc_add(0xF,0x1)=0x1.
- Corrupted checksum: 0x3, 0x5, 0x6(last) -> sum_out=0xE, pass=0, overflow=0; with OC_CHK_ERR_COUNT_EN, err_count=1.
- Overflow, MAX_WORDS=4: five words, none last -> done after the 4th, overflow=1, pass=0. The 5th word starts a new frame with word_count=1.
- Reset mid-frame: 0x3, 0x5 then reset high for one cycle -> all outputs 0, no done. The following frame 0xF(last) -> pass=1, word_count=1.
- Handshake and bubble:
  - Back-to-back frames with in_valid held high -> in_ready=0 exactly in the RESULT cycle and the word there is held, not lost.
  - Random in_valid gaps leave results unchanged.
  - An all-zero frame 0x0, 0x0(last) -> pass=0.
